// File: rtl/key_scan_pkg.sv
// Shared types and helpers for the key_scan push-button front end.
package key_scan_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } ch_state_t;

    // Divide first so large clock rates times long hold times stay inside 32 bits.
    function automatic int cyc_from_ms(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/key_scan_ch.sv
// One push-button channel: synchronizer, debounce FSM and hold timer.
// Optional long-press detection is built when KEY_SCAN_LONG_PRESS_EN is defined.
module key_scan_ch
    import key_scan_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int LONG_CYC     = 10
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_n,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_CYC);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);

    function automatic logic [DEB_W-1:0] deb_inc(input logic [DEB_W-1:0] v);
        return (v >= DEB_MAX) ? DEB_MAX : v + 1'b1;
    endfunction

    logic      sync_p0;
    logic      sync_p1;
    logic      pressed;
    ch_state_t state;
    logic [DEB_W-1:0] deb_cnt;
    logic      accept_press;

    // Synchronizer stores the inverted key so a cleared flop means "released".
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= ~key_n;
            sync_p1 <= sync_p0;
        end
    end

    assign pressed      = sync_p1;
    assign accept_press = (state == PRESS_WAIT) && pressed && (deb_cnt == DEB_LAST);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (pressed) begin
                        state   <= PRESS_WAIT;
                        deb_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed) begin
                        state <= IDLE;
                    end else if (deb_cnt == DEB_LAST) begin
                        state       <= HELD;
                        level       <= 1'b1;
                        press_pulse <= 1'b1;
                    end else begin
                        deb_cnt <= deb_inc(deb_cnt);
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        state   <= RELEASE_WAIT;
                        deb_cnt <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed) begin
                        state <= HELD;
                    end else if (deb_cnt == DEB_LAST) begin
                        state         <= IDLE;
                        level         <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        deb_cnt <= deb_inc(deb_cnt);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KEY_SCAN_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYC);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

    function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] v);
        return (v >= HOLD_MAX) ? HOLD_MAX : v + 1'b1;
    endfunction

    logic [HOLD_W-1:0] hold_cnt;
    logic              long_fired;

    // Hold time accumulates only in HELD, so short release glitches pause it.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hold_cnt   <= '0;
            long_fired <= 1'b0;
            long_pulse <= 1'b0;
        end else begin
            long_pulse <= 1'b0;
            if (accept_press) begin
                hold_cnt   <= '0;
                long_fired <= 1'b0;
            end else if (state == HELD) begin
                if ((hold_cnt == HOLD_LAST) && !long_fired) begin
                    long_pulse <= 1'b1;
                    long_fired <= 1'b1;
                end
                hold_cnt <= hold_inc(hold_cnt);
            end
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_scan.sv
// Multi-channel debounced push-button scanner with press/release/long events.
// Optional long-press detection is built when KEY_SCAN_LONG_PRESS_EN is defined.
module key_scan
    import key_scan_pkg::*;
#(
    parameter int NUM_KEYS    = 2,
    parameter int CLK_HZ      = 27_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    localparam int DEBOUNCE_CYC = cyc_from_ms(CLK_HZ, DEBOUNCE_MS);
    localparam int LONG_CYC     = cyc_from_ms(CLK_HZ, LONG_MS);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_scan_ch #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .LONG_CYC    (LONG_CYC)
        ) u_ch (
            .sys_clk      (sys_clk),
            .sys_rst      (sys_rst),
            .key_n        (key_n[i]),
            .level        (key_level[i]),
            .press_pulse  (key_press[i]),
            .release_pulse(key_release[i]),
            .long_pulse   (key_long[i])
        );
    end

endmodule

// File: tb/tb_key_scan.sv
// Scoreboard bench for key_scan at CLK_HZ=1000, DEBOUNCE_MS=4, LONG_MS=10.
`timescale 1ns/1ps
module tb_key_scan;
    import key_scan_pkg::*;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  press;
        logic [1:0]  rel;
        logic [1:0]  lng;
    } ev_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic [1:0] key_n   = 2'b11;
    logic [1:0] key_level, key_press, key_release, key_long;

    ev_t exp_q[$];
    int  checks = 0;
    int  passed = 0;
    int  cyc    = 0;

    key_scan #(
        .NUM_KEYS   (2),
        .CLK_HZ     (1000),
        .DEBOUNCE_MS(4),
        .LONG_MS    (10)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .key_n      (key_n),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic push_ev(input int c, input logic [1:0] p, input logic [1:0] r, input logic [1:0] l);
        exp_q.push_back('{cyc: c, press: p, rel: r, lng: l});
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge sys_clk);
    endtask

    // Every non-zero pulse vector is matched against the next expected event.
    task automatic monitor_events();
        ev_t obs, want;
        forever begin
            @(negedge sys_clk);
            if ((key_press | key_release | key_long) !== 2'b00) begin
                obs = '{cyc: cyc, press: key_press, rel: key_release, lng: key_long};
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_event: got cyc=%0d press=%b release=%b long=%b, required no event",
                             obs.cyc, obs.press, obs.rel, obs.lng);
                end else begin
                    want = exp_q.pop_front();
                    if (obs !== want)
                        $display("FAIL event: got cyc=%0d press=%b release=%b long=%b, required cyc=%0d press=%b release=%b long=%b",
                                 obs.cyc, obs.press, obs.rel, obs.lng, want.cyc, want.press, want.rel, want.lng);
                    else
                        passed++;
                end
            end
        end
    endtask

    task automatic test_reset();
        #1 sys_rst = 1'b1;
        @(negedge sys_clk);
        checks++;
        if ({key_level, key_press, key_release, key_long} !== 8'h00)
            $display("FAIL reset_outputs: got %h, required 00", {key_level, key_press, key_release, key_long});
        else passed++;
        checks++;
        if (dut.g_ch[0].u_ch.state !== IDLE)
            $display("FAIL reset_state: got %0d, required %0d", dut.g_ch[0].u_ch.state, IDLE);
        else passed++;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic test_clean_press();
        int p, r;
        @(negedge sys_clk);
        key_n[0] = 1'b0;
        p = cyc;
        push_ev(p + 7, 2'b01, 2'b00, 2'b00);
`ifdef KEY_SCAN_LONG_PRESS_EN
        push_ev(p + 17, 2'b00, 2'b00, 2'b01);
`endif
        wait_until(p + 6);
        checks++;
        if (key_level !== 2'b00) $display("FAIL press_level_early: got %b, required 00", key_level);
        else passed++;
        wait_until(p + 7);
        checks++;
        if (key_level !== 2'b01) $display("FAIL press_level: got %b, required 01", key_level);
        else passed++;
        wait_until(p + 27);
        key_n[0] = 1'b1;
        r = cyc;
        push_ev(r + 7, 2'b00, 2'b01, 2'b00);
        wait_until(r + 6);
        checks++;
        if (key_level !== 2'b01) $display("FAIL release_level_early: got %b, required 01", key_level);
        else passed++;
        wait_until(r + 10);
        checks++;
        if (key_level !== 2'b00) $display("FAIL release_level: got %b, required 00", key_level);
        else passed++;
        checks++;
        if (exp_q.size() !== 0) begin
            $display("FAIL clean_pending: got %0d events outstanding, required 0", exp_q.size());
            exp_q.delete();
        end else passed++;
    endtask

    task automatic test_bounce();
        int b;
        @(negedge sys_clk);
        key_n[0] = 1'b0;
        b = cyc;
        wait_until(b + 2); key_n[0] = 1'b1;
        wait_until(b + 3); key_n[0] = 1'b0;
        wait_until(b + 5); key_n[0] = 1'b1;
        wait_until(b + 12);
        checks++;
        if (key_level !== 2'b00) $display("FAIL bounce_level: got %b, required 00", key_level);
        else passed++;
        checks++;
        if (dut.g_ch[0].u_ch.state !== IDLE)
            $display("FAIL bounce_state: got %0d, required %0d", dut.g_ch[0].u_ch.state, IDLE);
        else passed++;
        checks++;
        if (exp_q.size() !== 0) begin
            $display("FAIL bounce_pending: got %0d, required 0", exp_q.size());
            exp_q.delete();
        end else passed++;
    endtask

    task automatic test_release_glitch();
        int g, r;
        @(negedge sys_clk);
        key_n[0] = 1'b0;
        g = cyc;
        push_ev(g + 7, 2'b01, 2'b00, 2'b00);
`ifdef KEY_SCAN_LONG_PRESS_EN
        push_ev(g + 17, 2'b00, 2'b00, 2'b01);
`endif
        wait_until(g + 20); key_n[0] = 1'b1;
        wait_until(g + 22); key_n[0] = 1'b0;
        wait_until(g + 30);
        checks++;
        if (key_level !== 2'b01) $display("FAIL glitch_level: got %b, required 01", key_level);
        else passed++;
        key_n[0] = 1'b1;
        r = cyc;
        push_ev(r + 7, 2'b00, 2'b01, 2'b00);
        wait_until(r + 10);
        checks++;
        if (key_level !== 2'b00) $display("FAIL glitch_release_level: got %b, required 00", key_level);
        else passed++;
        checks++;
        if (exp_q.size() !== 0) begin
            $display("FAIL glitch_pending: got %0d, required 0", exp_q.size());
            exp_q.delete();
        end else passed++;
    endtask

    task automatic test_simultaneous();
        int s, r;
        @(negedge sys_clk);
        key_n = 2'b00;
        s = cyc;
        push_ev(s + 7, 2'b11, 2'b00, 2'b00);
`ifdef KEY_SCAN_LONG_PRESS_EN
        push_ev(s + 17, 2'b00, 2'b00, 2'b11);
`endif
        wait_until(s + 8);
        checks++;
        if (key_level !== 2'b11) $display("FAIL simul_level: got %b, required 11", key_level);
        else passed++;
        wait_until(s + 25);
        key_n = 2'b11;
        r = cyc;
        push_ev(r + 7, 2'b00, 2'b11, 2'b00);
        wait_until(r + 10);
        checks++;
        if (exp_q.size() !== 0) begin
            $display("FAIL simul_pending: got %0d, required 0", exp_q.size());
            exp_q.delete();
        end else passed++;
    endtask

    task automatic test_reset_mid_hold();
        int p, d, r;
        @(negedge sys_clk);
        key_n[1] = 1'b0;
        p = cyc;
        push_ev(p + 7, 2'b10, 2'b00, 2'b00);
        wait_until(p + 8);
        checks++;
        if (key_level !== 2'b10) $display("FAIL midhold_level: got %b, required 10", key_level);
        else passed++;
        #2 sys_rst = 1'b1;
        #1;
        checks++;
        if ({key_level, key_press, key_release, key_long} !== 8'h00)
            $display("FAIL midhold_async_reset: got %h, required 00", {key_level, key_press, key_release, key_long});
        else passed++;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        d = cyc;
        push_ev(d + 7, 2'b10, 2'b00, 2'b00);
        wait_until(d + 6);
        checks++;
        if (key_level !== 2'b00) $display("FAIL midhold_relevel_early: got %b, required 00", key_level);
        else passed++;
        wait_until(d + 9);
        checks++;
        if (key_level !== 2'b10) $display("FAIL midhold_relevel: got %b, required 10", key_level);
        else passed++;
        key_n[1] = 1'b1;
        r = cyc;
        push_ev(r + 7, 2'b00, 2'b10, 2'b00);
        wait_until(r + 10);
        checks++;
        if (exp_q.size() !== 0) begin
            $display("FAIL midhold_pending: got %0d, required 0", exp_q.size());
            exp_q.delete();
        end else passed++;
    endtask

    initial begin
        fork
            monitor_events();
        join_none
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_simultaneous();
        test_reset_mid_hold();
        repeat (3) @(negedge sys_clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
